// File: rtl/fft_bitrev_in_buf_if.sv
// Stream bundle for the FFT input reorder buffer.
// The natural-order sample input and the bit-reversed output to the FFT core share one bundle.
interface fft_bitrev_in_buf_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;

    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic [AW-1:0]        out_idx;
    logic                 out_last;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last
    );
endinterface

// File: rtl/fft_bitrev_in_buf.sv
// Single-frame input buffer for the FFT core.
// It collects NO_POINT samples in natural order, then replays them in bit-reversed index order.
module fft_bitrev_in_buf #(
    parameter int NO_POINT    = 8,
    parameter int IN_INT_BIT  = 8,
    parameter int IN_FRAC_BIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    fft_bitrev_in_buf_if.slave    bus,
    output logic                  frame_done
);
    localparam int DW = IN_INT_BIT + IN_FRAC_BIT;
    localparam int AW = $clog2(NO_POINT);
    localparam logic [AW-1:0] LAST_IDX = AW'(NO_POINT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic [AW-1:0]        wr_cnt;
    logic [AW-1:0]        rd_cnt;
    logic [2*DW-1:0]      mem [NO_POINT];
    logic signed [DW-1:0] out_re_q;
    logic signed [DW-1:0] out_im_q;
    logic                 wr_fire;
    logic                 rd_fire;
    logic                 rd_last;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] i);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) begin
            r[b] = i[AW-1-b];
        end
        return r;
    endfunction

    assign wr_fire = bus.in_valid && (state == FILL);
    assign rd_fire = bus.out_ready && (state == DRAIN);
    assign rd_last = (rd_cnt == LAST_IDX);

    assign bus.in_ready  = (state == FILL);
    assign bus.out_valid = (state == DRAIN);
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.out_idx   = rd_cnt;
    assign bus.out_last  = (state == DRAIN) && rd_last;

    // Sample storage; contents are meaningless after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_fire && !flush) begin
            mem[wr_cnt] <= {bus.in_re, bus.in_im};
        end
    end

    // The output word is registered and prefetched, so it is stable while the core stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            out_re_q   <= '0;
            out_im_q   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (flush) begin
                state  <= FILL;
                wr_cnt <= '0;
                rd_cnt <= '0;
            end else begin
                case (state)
                    IDLE: state <= FILL;
                    FILL: begin
                        if (wr_fire) begin
                            if (wr_cnt == LAST_IDX) begin
                                state  <= DRAIN;
                                wr_cnt <= '0;
                                rd_cnt <= '0;
                                // Slot 0 maps to itself and was written at the start of this frame.
                                {out_re_q, out_im_q} <= mem[bitrev('0)];
                            end else begin
                                wr_cnt <= wr_cnt + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (rd_fire) begin
                            if (rd_last) begin
                                state      <= FILL;
                                rd_cnt     <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                rd_cnt <= rd_cnt + 1'b1;
                                {out_re_q, out_im_q} <= mem[bitrev(rd_cnt + 1'b1)];
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fft_bitrev_in_buf.sv
// Randomized bench for fft_bitrev_in_buf.
// A queue-based frame model predicts the handshakes, the reordered data and frame_done.
module tb_fft_bitrev_in_buf;
    localparam int NP = 8;
    localparam int IB = 8;
    localparam int FB = 8;
    localparam int DW = IB + FB;
    localparam int AW = 3;

    typedef struct {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        int                   idx;
        bit                   last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic frame_done;

    always #5 clk = ~clk;

    fft_bitrev_in_buf_if #(.DW(DW), .AW(AW)) bus ();

    fft_bitrev_in_buf #(
        .NO_POINT(NP), .IN_INT_BIT(IB), .IN_FRAC_BIT(FB)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus), .frame_done(frame_done)
    );

    logic [2*DW-1:0] fillq[$];
    beat_t           drainq[$];
    int              phase;      // 0 idle, 1 fill, 2 drain
    bit              exp_fd;
    int              vectors = 0;
    int              miscompares = 0;
    int              exp2[NP] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int              exp5[NP] = '{100, 104, 102, 106, 101, 105, 103, 107};

    function automatic int brev(int i);
        int r = 0;
        for (int b = 0; b < AW; b++)
            if ((i & (1 << b)) != 0) r += NP >> (b + 1);
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("in_ready", {63'd0, bus.in_ready}, {63'd0, phase == 1});
        check_eq("out_valid", {63'd0, bus.out_valid}, {63'd0, phase == 2});
        check_eq("frame_done", {63'd0, frame_done}, {63'd0, exp_fd});
        if (phase == 2 && drainq.size() > 0) begin
            check_eq("out_re", 64'(bus.out_re), 64'(drainq[0].re));
            check_eq("out_im", 64'(bus.out_im), 64'(drainq[0].im));
            check_eq("out_idx", 64'(bus.out_idx), 64'(drainq[0].idx));
            check_eq("out_last", {63'd0, bus.out_last}, {63'd0, drainq[0].last});
        end else begin
            check_eq("out_last_idle", {63'd0, bus.out_last}, 64'd0);
        end
    endtask

    task automatic model_reset();
        phase = 0;
        exp_fd = 1'b0;
        fillq.delete();
        drainq.delete();
    endtask

    task automatic tick(input bit iv, input logic signed [DW-1:0] re,
                        input logic signed [DW-1:0] im, input bit ordy, input bit fl);
        beat_t b;
        bus.in_valid  = iv;
        bus.in_re     = re;
        bus.in_im     = im;
        bus.out_ready = ordy;
        flush         = fl;
        exp_fd        = 1'b0;
        if (fl) begin
            phase = 1;
            fillq.delete();
            drainq.delete();
        end else begin
            case (phase)
                0: phase = 1;
                1: if (iv) begin
                    fillq.push_back({re, im});
                    if (fillq.size() == NP) begin
                        for (int j = 0; j < NP; j++) begin
                            b.re   = fillq[brev(j)][2*DW-1:DW];
                            b.im   = fillq[brev(j)][DW-1:0];
                            b.idx  = j;
                            b.last = (j == NP - 1);
                            drainq.push_back(b);
                        end
                        fillq.delete();
                        phase = 2;
                    end
                end
                default: if (ordy) begin
                    drainq.delete(0);
                    if (drainq.size() == 0) begin
                        phase  = 1;
                        exp_fd = 1'b1;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check_eq("rst_out_re", 64'(bus.out_re), 64'd0);
        check_eq("rst_out_idx", 64'(bus.out_idx), 64'd0);
        rst = 1'b0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < NP; k++) tick(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        // Reset and leave IDLE
        apply_reset();
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b0);

        // Ramp frame with full-rate drain
        for (int k = 0; k < NP; k++) tick(1'b1, DW'(k), DW'(-k), 1'b1, 1'b0);
        for (int j = 0; j < NP; j++) begin
            check_eq("t2_seq", 64'(bus.out_re), 64'(exp2[j]));
            tick(1'b0, '0, '0, 1'b1, 1'b0);
        end
        tick(1'b0, '0, '0, 1'b1, 1'b0);

        // Backpressure 1,0,0,1 during drain
        fill_random();
        for (int i = 0; i < 40 && phase == 2; i++)
            tick(1'b0, '0, '0, (i % 4 == 0) || (i % 4 == 3), 1'b0);
        check_eq("t3_drained", 64'(phase), 64'd1);

        // Gapped input; in_valid held high through drain
        for (int i = 0; i < 16; i++) tick(i[0], DW'($urandom), DW'($urandom), 1'b0, 1'b0);
        check_eq("t4_in_drain", 64'(phase), 64'd2);
        for (int i = 0; i < 30 && phase == 2; i++)
            tick(1'b1, DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        // Flush away any samples that slipped in after the drain
        tick(1'b0, '0, '0, 1'b0, 1'b1);

        // Flush after 5 writes, with a same-cycle write
        for (int k = 0; k < 5; k++) tick(1'b1, DW'(50 + k), DW'(k), 1'b0, 1'b0);
        tick(1'b1, DW'(99), DW'(99), 1'b0, 1'b1);
        for (int k = 0; k < NP; k++) tick(1'b1, DW'(100 + k), DW'(k), 1'b1, 1'b0);
        for (int j = 0; j < NP; j++) begin
            check_eq("t5_seq", 64'(bus.out_re), 64'(exp5[j]));
            tick(1'b0, '0, '0, 1'b1, 1'b0);
        end

        // Async reset during drain beat 3
        fill_random();
        for (int j = 0; j < 3; j++) tick(1'b0, '0, '0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_async_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check_eq("t6_async_in_ready", {63'd0, bus.in_ready}, 64'd0);
        apply_reset();
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        fill_random();
        for (int j = 0; j < NP + 1; j++) tick(1'b0, '0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++)
            tick(1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
